// File: rtl/axi_perf_snoop_pkg.sv
//============================================================================
// Module      : axi_perf_snoop_pkg
// Description : Shared types for the AXI4 performance snoop. Holds the
//               statistics record, default field widths, the channel event
//               index and a minimal default AXI4 request/response pair used
//               when the instantiating design does not supply its own types.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

package axi_perf_snoop_pkg;

   // Widths of the statistics record. Instances built with narrower
   // counters zero-extend into these fields.
   localparam int CNT_WIDTH   = 64;
   localparam int OUTST_WIDTH = 8;

   // Index of each per-channel handshake event.
   typedef enum logic [2:0] {
      EvAw    = 3'd0,
      EvW     = 3'd1,
      EvB     = 3'd2,
      EvAr    = 3'd3,
      EvR     = 3'd4,
      EvRLast = 3'd5
   } ev_idx_e;

   localparam int NUM_EV = 6;

   typedef struct packed {
      logic [CNT_WIDTH-1:0]   cycle;
      logic [CNT_WIDTH-1:0]   aw;
      logic [CNT_WIDTH-1:0]   w;
      logic [CNT_WIDTH-1:0]   b;
      logic [CNT_WIDTH-1:0]   ar;
      logic [CNT_WIDTH-1:0]   r;
      logic [CNT_WIDTH-1:0]   r_last;
      logic [CNT_WIDTH-1:0]   wr_outst_sum;
      logic [CNT_WIDTH-1:0]   rd_outst_sum;
      logic [OUTST_WIDTH-1:0] wr_outst_max;
      logic [OUTST_WIDTH-1:0] rd_outst_max;
   } perf_stats_t;

   // Minimal AXI4 channel payloads for the default request/response types.
   typedef struct packed {
      logic [3:0]  id;
      logic [31:0] addr;
      logic [7:0]  len;
   } axi_ax_chan_t;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  strb;
      logic        last;
   } axi_w_chan_t;

   typedef struct packed {
      logic [3:0] id;
      logic [1:0] resp;
   } axi_b_chan_t;

   typedef struct packed {
      logic [3:0]  id;
      logic [31:0] data;
      logic [1:0]  resp;
      logic        last;
   } axi_r_chan_t;

   typedef struct packed {
      axi_ax_chan_t aw;
      logic         aw_valid;
      axi_w_chan_t  w;
      logic         w_valid;
      logic         b_ready;
      axi_ax_chan_t ar;
      logic         ar_valid;
      logic         r_ready;
   } axi_req_default_t;

   typedef struct packed {
      logic        aw_ready;
      logic        ar_ready;
      logic        w_ready;
      axi_b_chan_t b;
      logic        b_valid;
      axi_r_chan_t r;
      logic        r_valid;
   } axi_rsp_default_t;

endpackage

`default_nettype wire

// File: rtl/axi_perf_cnt.sv
//============================================================================
// Module      : axi_perf_cnt
// Description : Saturating accumulator. Adds inc_val each enabled cycle and
//               sticks at all-ones instead of wrapping.
// Ports       : clk_i, rst_i (sync, active-high), en (advance), clr (sync
//               clear, below reset in priority), inc_val (addend), cnt (value)
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module axi_perf_cnt
   import axi_perf_snoop_pkg::*;
#(
   parameter int WIDTH = CNT_WIDTH
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en,
   input  logic             clr,
   input  logic [WIDTH-1:0] inc_val,
   output logic [WIDTH-1:0] cnt
);

   logic [WIDTH-1:0] r_cnt;
   logic [WIDTH:0]   w_sum;

   // One extra bit catches the carry that signals saturation.
   assign w_sum = {1'b0, r_cnt} + {1'b0, inc_val};

   always_ff @(posedge clk_i) begin
      if (rst_i || clr) begin
         r_cnt <= '0;
      end else if (en) begin
         r_cnt <= w_sum[WIDTH] ? '1 : w_sum[WIDTH-1:0];
      end
   end

   assign cnt = r_cnt;

endmodule

`default_nettype wire

// File: rtl/axi_perf_snoop.sv
//============================================================================
// Module      : axi_perf_snoop
// Description : Transparent AXI4 monitor. Forwards request/response
//               unchanged and collects handshake counts, cycle count,
//               in-flight read/write trackers and outstanding-time
//               integrals for average-latency estimation.
// Ports       : clk_i, rst_i (sync, active-high), enable_i, clear_i,
//               axi_req_i/axi_rsp_i (snooped bus), axi_req_o/axi_rsp_o
//               (pass-through), stats_o (counters), wr_outst_o/rd_outst_o
//               (in-flight trackers), err_o (sticky tracker under/overflow)
// Config      : AXI_PERF_SNOOP_WATERMARK_EN adds tracker high-water marks
//               to stats_o; otherwise those fields read 0.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module axi_perf_snoop
   import axi_perf_snoop_pkg::*;
#(
   parameter type axi_req_t  = axi_req_default_t,
   parameter type axi_rsp_t  = axi_rsp_default_t,
   parameter int  CntWidth   = CNT_WIDTH,
   parameter int  OutstWidth = OUTST_WIDTH
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  enable_i,
   input  logic                  clear_i,
   input  axi_req_t              axi_req_i,
   input  axi_rsp_t              axi_rsp_i,
   output axi_req_t              axi_req_o,
   output axi_rsp_t              axi_rsp_o,
   output perf_stats_t           stats_o,
   output logic [OutstWidth-1:0] wr_outst_o,
   output logic [OutstWidth-1:0] rd_outst_o,
   output logic                  err_o
);

   // Pure wires: the monitor only observes the handshakes.
   assign axi_req_o = axi_req_i;
   assign axi_rsp_o = axi_rsp_i;

   logic [NUM_EV-1:0]     w_ev;
   logic [CntWidth-1:0]   w_ev_cnt [NUM_EV];
   logic [CntWidth-1:0]   w_cycle_cnt;
   logic [CntWidth-1:0]   w_wr_sum;
   logic [CntWidth-1:0]   w_rd_sum;
   logic [OutstWidth-1:0] r_wr_outst;
   logic [OutstWidth-1:0] r_rd_outst;
   logic                  r_err;

   always_comb begin
      w_ev          = '0;
      w_ev[EvAw]    = axi_req_i.aw_valid & axi_rsp_i.aw_ready;
      w_ev[EvW]     = axi_req_i.w_valid  & axi_rsp_i.w_ready;
      w_ev[EvB]     = axi_rsp_i.b_valid  & axi_req_i.b_ready;
      w_ev[EvAr]    = axi_req_i.ar_valid & axi_rsp_i.ar_ready;
      w_ev[EvR]     = axi_rsp_i.r_valid  & axi_req_i.r_ready;
      w_ev[EvRLast] = axi_rsp_i.r_valid  & axi_req_i.r_ready & axi_rsp_i.r.last;
   end

   for (genvar i = 0; i < NUM_EV; i++) begin : g_ev_cnt
      axi_perf_cnt #(.WIDTH(CntWidth)) u_cnt (
         .clk_i   (clk_i),
         .rst_i   (rst_i),
         .en      (enable_i),
         .clr     (clear_i),
         .inc_val (CntWidth'(w_ev[i])),
         .cnt     (w_ev_cnt[i])
      );
   end

   axi_perf_cnt #(.WIDTH(CntWidth)) u_cycle_cnt (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .en      (enable_i),
      .clr     (clear_i),
      .inc_val (CntWidth'(1)),
      .cnt     (w_cycle_cnt)
   );

   // Integrals accumulate the tracker value present before this cycle's
   // handshakes, so a transaction contributes one per cycle it is in flight.
   axi_perf_cnt #(.WIDTH(CntWidth)) u_wr_sum (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .en      (enable_i),
      .clr     (clear_i),
      .inc_val (CntWidth'(r_wr_outst)),
      .cnt     (w_wr_sum)
   );

   axi_perf_cnt #(.WIDTH(CntWidth)) u_rd_sum (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .en      (enable_i),
      .clr     (clear_i),
      .inc_val (CntWidth'(r_rd_outst)),
      .cnt     (w_rd_sum)
   );

   // Trackers ignore enable/clear so they stay coherent with bus traffic.
   // Simultaneous start and finish leave the count unchanged.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_wr_outst <= '0;
         r_rd_outst <= '0;
         r_err      <= 1'b0;
      end else begin
         if (w_ev[EvAw] && !w_ev[EvB]) begin
            if (&r_wr_outst) r_err <= 1'b1;
            else             r_wr_outst <= r_wr_outst + OutstWidth'(1);
         end else if (w_ev[EvB] && !w_ev[EvAw]) begin
            if (r_wr_outst == '0) r_err <= 1'b1;
            else                  r_wr_outst <= r_wr_outst - OutstWidth'(1);
         end
         if (w_ev[EvAr] && !w_ev[EvRLast]) begin
            if (&r_rd_outst) r_err <= 1'b1;
            else             r_rd_outst <= r_rd_outst + OutstWidth'(1);
         end else if (w_ev[EvRLast] && !w_ev[EvAr]) begin
            if (r_rd_outst == '0) r_err <= 1'b1;
            else                  r_rd_outst <= r_rd_outst - OutstWidth'(1);
         end
      end
   end

`ifdef AXI_PERF_SNOOP_WATERMARK_EN
   // High-water marks sample the same pre-update tracker value as the sums.
   logic [OutstWidth-1:0] r_wr_max;
   logic [OutstWidth-1:0] r_rd_max;

   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         r_wr_max <= '0;
         r_rd_max <= '0;
      end else if (enable_i) begin
         if (r_wr_outst > r_wr_max) r_wr_max <= r_wr_outst;
         if (r_rd_outst > r_rd_max) r_rd_max <= r_rd_outst;
      end
   end
`endif

   always_comb begin
      stats_o              = '0;
      stats_o.cycle        = CNT_WIDTH'(w_cycle_cnt);
      stats_o.aw           = CNT_WIDTH'(w_ev_cnt[EvAw]);
      stats_o.w            = CNT_WIDTH'(w_ev_cnt[EvW]);
      stats_o.b            = CNT_WIDTH'(w_ev_cnt[EvB]);
      stats_o.ar           = CNT_WIDTH'(w_ev_cnt[EvAr]);
      stats_o.r            = CNT_WIDTH'(w_ev_cnt[EvR]);
      stats_o.r_last       = CNT_WIDTH'(w_ev_cnt[EvRLast]);
      stats_o.wr_outst_sum = CNT_WIDTH'(w_wr_sum);
      stats_o.rd_outst_sum = CNT_WIDTH'(w_rd_sum);
`ifdef AXI_PERF_SNOOP_WATERMARK_EN
      stats_o.wr_outst_max = OUTST_WIDTH'(r_wr_max);
      stats_o.rd_outst_max = OUTST_WIDTH'(r_rd_max);
`endif
   end

   assign wr_outst_o = r_wr_outst;
   assign rd_outst_o = r_rd_outst;
   assign err_o      = r_err;

endmodule

`default_nettype wire

// File: tb/tb_axi_perf_snoop.sv
//============================================================================
// Module      : tb_axi_perf_snoop
// Description : Self-checking bench for axi_perf_snoop. Drives a default
//               instance and a narrow one (4-bit counters, 2-bit trackers)
//               with the same traffic, compares both against a behavioural
//               model every cycle, and pins key results to literals.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_axi_perf_snoop;
   import axi_perf_snoop_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst, enable, clear;
   axi_req_default_t req, req_o0, req_o1;
   axi_rsp_default_t rsp, rsp_o0, rsp_o1;
   perf_stats_t      st0, st1;
   logic [7:0]       wr0, rd0;
   logic [1:0]       wr1, rd1;
   logic             err0, err1;

   axi_perf_snoop u_dut (
      .clk_i(clk), .rst_i(rst), .enable_i(enable), .clear_i(clear),
      .axi_req_i(req), .axi_rsp_i(rsp), .axi_req_o(req_o0), .axi_rsp_o(rsp_o0),
      .stats_o(st0), .wr_outst_o(wr0), .rd_outst_o(rd0), .err_o(err0)
   );

   axi_perf_snoop #(.CntWidth(4), .OutstWidth(2)) u_dut_small (
      .clk_i(clk), .rst_i(rst), .enable_i(enable), .clear_i(clear),
      .axi_req_i(req), .axi_rsp_i(rsp), .axi_req_o(req_o1), .axi_rsp_o(rsp_o1),
      .stats_o(st1), .wr_outst_o(wr1), .rd_outst_o(rd1), .err_o(err1)
   );

   int checks = 0;
   int errors = 0;
   bit chk_en = 0;

   // Model state: [instance][cycle, aw, w, b, ar, r, r_last, wr_sum, rd_sum]
   logic [63:0] m_cnt [2][9];
   int          m_out [2][2];
   int          m_max [2][2];
   bit          m_err [2];
   bit          ev    [6];
   int          pre   [2];
   bit          inc, dec;

   function automatic logic [63:0] cmax(input int k);
      return (k == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'd15;
   endfunction

   function automatic int omax(input int k);
      return (k == 0) ? 255 : 3;
   endfunction

   function automatic logic [63:0] sadd(input logic [63:0] a, b, mx);
      logic [64:0] s;
      s = {1'b0, a} + {1'b0, b};
      return (s > {1'b0, mx}) ? mx : s[63:0];
   endfunction

   task automatic check(input string name, input logic [63:0] act, exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: applies the counting rules to the bus as sampled at
   // each rising edge.
   initial forever begin
      @(posedge clk);
      ev[0] = req.aw_valid && rsp.aw_ready;
      ev[1] = req.w_valid  && rsp.w_ready;
      ev[2] = rsp.b_valid  && req.b_ready;
      ev[3] = req.ar_valid && rsp.ar_ready;
      ev[4] = rsp.r_valid  && req.r_ready;
      ev[5] = rsp.r_valid  && req.r_ready && rsp.r.last;
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            for (int i = 0; i < 9; i++) m_cnt[k][i] = 64'd0;
            for (int c = 0; c < 2; c++) begin
               m_out[k][c] = 0;
               m_max[k][c] = 0;
            end
            m_err[k] = 1'b0;
         end else begin
            pre[0] = m_out[k][0];
            pre[1] = m_out[k][1];
            if (clear) begin
               for (int i = 0; i < 9; i++) m_cnt[k][i] = 64'd0;
               m_max[k][0] = 0;
               m_max[k][1] = 0;
            end else if (enable) begin
               m_cnt[k][0] = sadd(m_cnt[k][0], 64'd1, cmax(k));
               for (int e = 0; e < 6; e++)
                  if (ev[e]) m_cnt[k][1+e] = sadd(m_cnt[k][1+e], 64'd1, cmax(k));
               m_cnt[k][7] = sadd(m_cnt[k][7], 64'(pre[0]), cmax(k));
               m_cnt[k][8] = sadd(m_cnt[k][8], 64'(pre[1]), cmax(k));
               for (int c = 0; c < 2; c++)
                  if (pre[c] > m_max[k][c]) m_max[k][c] = pre[c];
            end
            for (int c = 0; c < 2; c++) begin
               inc = (c == 0) ? ev[0] : ev[3];
               dec = (c == 0) ? ev[2] : ev[5];
               if (inc && !dec) begin
                  if (m_out[k][c] == omax(k)) m_err[k] = 1'b1;
                  else m_out[k][c] = m_out[k][c] + 1;
               end else if (dec && !inc) begin
                  if (m_out[k][c] == 0) m_err[k] = 1'b1;
                  else m_out[k][c] = m_out[k][c] - 1;
               end
            end
         end
      end
   end

   task automatic cmp_inst(input int k, input perf_stats_t s,
                           input logic [63:0] wr, rd, input logic er);
      string p;
      p = (k == 0) ? "def_" : "small_";
      check({p, "cycle"},        s.cycle,        m_cnt[k][0]);
      check({p, "aw"},           s.aw,           m_cnt[k][1]);
      check({p, "w"},            s.w,            m_cnt[k][2]);
      check({p, "b"},            s.b,            m_cnt[k][3]);
      check({p, "ar"},           s.ar,           m_cnt[k][4]);
      check({p, "r"},            s.r,            m_cnt[k][5]);
      check({p, "r_last"},       s.r_last,       m_cnt[k][6]);
      check({p, "wr_outst_sum"}, s.wr_outst_sum, m_cnt[k][7]);
      check({p, "rd_outst_sum"}, s.rd_outst_sum, m_cnt[k][8]);
      check({p, "wr_outst"},     wr,             64'(m_out[k][0]));
      check({p, "rd_outst"},     rd,             64'(m_out[k][1]));
      check({p, "err"},          64'(er),        64'(m_err[k]));
`ifdef AXI_PERF_SNOOP_WATERMARK_EN
      check({p, "wr_max"}, 64'(s.wr_outst_max), 64'(m_max[k][0]));
      check({p, "rd_max"}, 64'(s.rd_outst_max), 64'(m_max[k][1]));
`else
      check({p, "wr_max"}, 64'(s.wr_outst_max), 64'd0);
      check({p, "rd_max"}, 64'(s.rd_outst_max), 64'd0);
`endif
   endtask

   // Compare process: outputs are settled at the falling edge.
   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         cmp_inst(0, st0, 64'(wr0), 64'(rd0), err0);
         cmp_inst(1, st1, 64'(wr1), 64'(rd1), err1);
         check("pass_req_def",   64'(req_o0 === req), 64'd1);
         check("pass_rsp_def",   64'(rsp_o0 === rsp), 64'd1);
         check("pass_req_small", 64'(req_o1 === req), 64'd1);
         check("pass_rsp_small", 64'(rsp_o1 === rsp), 64'd1);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      step();
      clear = 1'b0;
   endtask

   initial begin
      rst = 1'b1; enable = 1'b0; clear = 1'b0;
      req = '0;   rsp = '0;
      repeat (3) step();
      chk_en = 1'b1;
      check("reset_cycle",  st0.cycle, 64'd0);
      check("reset_wr_sum", st0.wr_outst_sum, 64'd0);
      check("reset_err",    64'(err0), 64'd0);

      // 100 idle enabled cycles
      rst = 1'b0; enable = 1'b1;
      repeat (100) step();
      check("t1_cycle",    st0.cycle, 64'd100);
      check("t1_aw",       st0.aw, 64'd0);
      check("t1_wr_outst", 64'(wr0), 64'd0);
      check("t1_err",      64'(err0), 64'd0);

      // three writes, each response five cycles after its address
      pulse_clear();
      repeat (3) begin
         req.aw_valid = 1'b1; rsp.aw_ready = 1'b1; step();
         req.aw_valid = 1'b0; rsp.aw_ready = 1'b0;
         repeat (4) step();
         rsp.b_valid = 1'b1; req.b_ready = 1'b1; step();
         rsp.b_valid = 1'b0; req.b_ready = 1'b0; step();
      end
      check("t2_aw",     st0.aw, 64'd3);
      check("t2_b",      st0.b, 64'd3);
      check("t2_wr_sum", st0.wr_outst_sum, 64'd15);
      check("t2_outst",  64'(wr0), 64'd0);

      // one read burst of four beats with a two-cycle ready stall
      req.ar_valid = 1'b1; rsp.ar_ready = 1'b1; step();
      req.ar_valid = 1'b0; rsp.ar_ready = 1'b0;
      rsp.r_valid = 1'b1; req.r_ready = 1'b1; rsp.r.last = 1'b0;
      repeat (2) step();
      req.r_ready = 1'b0;
      repeat (2) step();
      req.r_ready = 1'b1; step();
      rsp.r.last = 1'b1; step();
      rsp = '0; req = '0; step();
      check("t3_ar",     st0.ar, 64'd1);
      check("t3_r",      st0.r, 64'd4);
      check("t3_r_last", st0.r_last, 64'd1);
      check("t3_outst",  64'(rd0), 64'd0);

      // simultaneous AW and B, then underflow
      req.aw_valid = 1'b1; rsp.aw_ready = 1'b1;
      repeat (2) step();
      rsp.b_valid = 1'b1; req.b_ready = 1'b1; step();
      check("t4_same_cycle", 64'(wr0), 64'd2);
      req.aw_valid = 1'b0; rsp.aw_ready = 1'b0;
      repeat (2) step();
      check("t4_drained", 64'(wr0), 64'd0);
      check("t4_no_err",  64'(err0), 64'd0);
      step();
      rsp.b_valid = 1'b0; req.b_ready = 1'b0;
      check("t4_hold0",  64'(wr0), 64'd0);
      check("t4_err",    64'(err0), 64'd1);
      check("t4_err_sm", 64'(err1), 64'd1);

      // writes while disabled
      pulse_clear();
      enable = 1'b0;
      req.aw_valid = 1'b1; rsp.aw_ready = 1'b1;
      repeat (2) step();
      req = '0; rsp = '0;
      check("t6_aw",    st0.aw, 64'd0);
      check("t6_outst", 64'(wr0), 64'd2);
      enable = 1'b1; step();
`ifdef AXI_PERF_SNOOP_WATERMARK_EN
      check("t6_wr_max", 64'(st0.wr_outst_max), 64'd2);
`endif

      // narrow counters saturate; clear leaves trackers alone
      pulse_clear();
      repeat (20) step();
      check("t5_cycle_sat", st1.cycle, 64'd15);
      check("t5_sum_sat",   st1.wr_outst_sum, 64'd15);
      check("t5_cycle_def", st0.cycle, 64'd20);
      pulse_clear();
      check("t5_cleared",  st1.cycle, 64'd0);
      check("t5_trk_sm",   64'(wr1), 64'd2);
      check("t5_trk_def",  64'(wr0), 64'd2);

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         rst    = ($urandom_range(0, 999) == 0);
         clear  = ($urandom_range(0, 49) == 0);
         enable = ($urandom_range(0, 9) != 0);
         req.aw       = '{id: 4'($urandom()), addr: $urandom(), len: 8'($urandom())};
         req.aw_valid = 1'($urandom());
         req.w        = '{data: $urandom(), strb: 4'($urandom()), last: 1'($urandom())};
         req.w_valid  = 1'($urandom());
         req.b_ready  = 1'($urandom());
         req.ar       = '{id: 4'($urandom()), addr: $urandom(), len: 8'($urandom())};
         req.ar_valid = 1'($urandom());
         req.r_ready  = 1'($urandom());
         rsp.aw_ready = 1'($urandom());
         rsp.ar_ready = 1'($urandom());
         rsp.w_ready  = 1'($urandom());
         rsp.b        = '{id: 4'($urandom()), resp: 2'($urandom())};
         rsp.b_valid  = ($urandom_range(0, 2) == 0);
         rsp.r        = '{id: 4'($urandom()), data: $urandom(),
                          resp: 2'($urandom()), last: 1'($urandom())};
         rsp.r_valid  = 1'($urandom());
         step();
      end
      rst = 1'b0; clear = 1'b0;
      req = '0; rsp = '0;
      repeat (2) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
